// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-master arbiter that shares one physical memory port between the
//   instruction-fetch side (I) and the data side (D). One transaction is in
//   flight at a time. D normally wins a tie. I is forced through after
//   STARVE_LIMIT consecutive D grants that it spent waiting.
//
//   Every pmem_* strobe and payload comes from registers that are captured at
//   grant. Those registers stay frozen until memory completes the access.
//
// Parameters
//   STARVE_LIMIT  consecutive D grants tolerated while I waits (legal 1..15)
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   I_mem_read/address           fetch request and address
//   I_mem_rdata/resp             fetch read data and one-cycle completion
//   D_mem_read/write/address     data request, op and address
//   D_mem_wdata/byte_enable      data write payload and byte mask
//   D_mem_rdata/resp             data read data and one-cycle completion
//   pmem_read/write/address      physical memory strobes and address
//   pmem_wdata/byte_enable       physical memory write payload and mask
//   pmem_rdata/resp              physical memory read data and completion
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        I_mem_read,
    input  logic [15:0] I_mem_address,
    output logic [15:0] I_mem_rdata,
    output logic        I_mem_resp,

    input  logic        D_mem_read,
    input  logic        D_mem_write,
    input  logic [15:0] D_mem_address,
    input  logic [15:0] D_mem_wdata,
    input  logic [1:0]  D_mem_byte_enable,
    output logic [15:0] D_mem_rdata,
    output logic        D_mem_resp,

    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_address,
    output logic [15:0] pmem_wdata,
    output logic [1:0]  pmem_byte_enable,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q,      state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [15:0] addr_q,       addr_d;
    logic [15:0] wdata_q,      wdata_d;
    logic [1:0]  be_q,         be_d;
    logic        read_q,       read_d;
    logic        write_q,      write_d;

    logic d_req;
    logic i_req;
    logic grant_d;
    logic grant_i;

    assign d_req = D_mem_read | D_mem_write;
    assign i_req = I_mem_read;

    // D wins every tie, except once I has waited through LIMIT D grants.
    assign grant_d = d_req && !(i_req && (starve_cnt_q == LIMIT));
    assign grant_i = i_req && !grant_d;

    // Read data is a plain wire-through. The requester only looks at it
    // while its resp is high.
    assign I_mem_rdata = pmem_rdata;
    assign D_mem_rdata = pmem_rdata;

    assign pmem_read        = read_q;
    assign pmem_write       = write_q;
    assign pmem_address     = addr_q;
    assign pmem_wdata       = wdata_q;
    assign pmem_byte_enable = be_q;

    always_comb begin
        // NOTE: every output of this block gets a default before the case.
        // Any path that skipped an assignment would otherwise infer a latch.
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        read_d       = read_q;
        write_d      = write_q;
        I_mem_resp   = 1'b0;
        D_mem_resp   = 1'b0;

        case (state_q)
            IDLE: begin
                // pmem_resp is deliberately ignored here.
                if (grant_d) begin
                    state_d = BUSY_D;
                    addr_d  = D_mem_address;
                    wdata_d = D_mem_wdata;
                    be_d    = D_mem_byte_enable;
                    // Read and write both high is treated as a write.
                    write_d = D_mem_write;
                    read_d  = !D_mem_write;
                    if (i_req && (starve_cnt_q < LIMIT)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (grant_i) begin
                    state_d      = BUSY_I;
                    addr_d       = I_mem_address;
                    be_d         = 2'b11;
                    write_d      = 1'b0;
                    read_d       = 1'b1;
                    starve_cnt_d = 4'd0;
                end
            end

            BUSY_I: begin
                if (pmem_resp) begin
                    I_mem_resp = 1'b1;
                    state_d    = IDLE;
                    read_d     = 1'b0;
                    write_d    = 1'b0;
                end
            end

            BUSY_D: begin
                if (pmem_resp) begin
                    D_mem_resp = 1'b1;
                    state_d    = IDLE;
                    read_d     = 1'b0;
                    write_d    = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // Reset drops any access in flight. No resp is ever produced for it,
    // because resp requires a BUSY state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
            addr_q       <= 16'h0000;
            wdata_q      <= 16'h0000;
            be_q         <= 2'b00;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so that every flop
            // samples the values from before this edge.
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            read_q       <= read_d;
            write_q      <= write_d;
        end
    end

endmodule
